// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// Counter feature macro: SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

    localparam logic [3:0] DEF_PAT = 4'b1011;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// Bit history, fill tracking and pattern comparison.
// match_next is combinational and reflects the bit being accepted this cycle.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int FW      = fill_w(PAT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic               sequence_in,
    input  mode_e              mode,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               match_next
);

    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] history;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] hist_shift;
    logic [FW-1:0]      fill_inc;
    logic [FW-1:0]      fill_nxt;

    always_comb begin
        hist_shift = {history[PAT_LEN-2:0], sequence_in};
        fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
        match_next = shift && (fill_inc == FULL) && (hist_shift == pattern);
        // Non-overlapping mode demands a fresh window after every hit
        fill_nxt   = (match_next && mode == MODE_NONOVL) ? '0 : fill_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else begin
            unique case (1'b1)
                clear: begin
                    history <= '0;
                    fill    <= '0;
                end
                shift: begin
                    history <= hist_shift;
                    fill    <= fill_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with match pulse and counter.
// Define SEQ_DET_MATCH_CNT_EN to build match_count / count_sat.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(DEF_PAT),
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               valid_in,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               pattern_load,
    input  logic               overlap_en,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    logic [PAT_LEN-1:0] pattern_q;
    logic               shift;
    logic               match_next;
    mode_e              mode;

    // A load in the same cycle as a valid bit drops that bit
    assign shift = valid_in & ~pattern_load;
    assign mode  = mode_e'(overlap_en);

    seq_det_window #(
        .PAT_LEN (PAT_LEN)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .clear       (pattern_load),
        .shift       (shift),
        .sequence_in (sequence_in),
        .mode        (mode),
        .pattern     (pattern_q),
        .match_next  (match_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q    <= RESET_PAT;
            detector_out <= 1'b0;
        end else begin
            if (pattern_load) begin
                pattern_q <= pattern_in;
            end
            detector_out <= match_next;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign count_sat = (match_count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (match_next && !count_sat) begin
            match_count <= match_count + 1'b1;
        end
    end
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param.
// Count expectations follow SEQ_DET_MATCH_CNT_EN.
module tb_seq_detect_param;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sequence_in = 1'b0;
    logic       valid_in = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       pattern_load = 1'b0;
    logic       overlap_en = 1'b1;

    logic       detector_out;
    logic [7:0] match_count;
    logic       count_sat;
    logic       det2;
    logic [1:0] cnt2;
    logic       sat2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk          (clk),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .valid_in     (valid_in),
        .pattern_in   (pattern_in),
        .pattern_load (pattern_load),
        .overlap_en   (overlap_en),
        .detector_out (detector_out),
        .match_count  (match_count),
        .count_sat    (count_sat)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .valid_in     (valid_in),
        .pattern_in   (pattern_in),
        .pattern_load (pattern_load),
        .overlap_en   (overlap_en),
        .detector_out (det2),
        .match_count  (cnt2),
        .count_sat    (sat2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic b);
        valid_in    = v;
        sequence_in = b;
        tick();
        valid_in    = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        valid_in     = 1'b0;
        pattern_load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (detector_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_det got %b want 0", detector_out);
        end
        vectors++;
        if (match_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d want 0", match_count);
        end
        vectors++;
        if (count_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sat got %b want 0", count_sat);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        logic [7:0] ec;
        bits = 7'b1011011;
        exp  = 7'b0001001;
        ec   = CNT_EN ? 8'd2 : 8'd0;
        overlap_en = 1'b1;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            apply(1'b1, bits[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL ovl_det bit%0d got %b want %b", 7 - i, detector_out, exp[i]);
            end
        end
        vectors++;
        if (match_count !== ec) begin
            miscompares++;
            $display("FAIL ovl_cnt got %0d want %0d", match_count, ec);
        end
    endtask

    task automatic test_nonoverlap();
        logic [10:0] bits;
        logic [10:0] exp;
        logic [7:0]  ec;
        bits = 11'b1011011_1011;
        exp  = 11'b0001000_0001;
        overlap_en = 1'b0;
        do_reset();
        for (int i = 10; i >= 0; i--) begin
            apply(1'b1, bits[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL novl_det bit%0d got %b want %b", 11 - i, detector_out, exp[i]);
            end
            if (i == 4) begin
                ec = CNT_EN ? 8'd1 : 8'd0;
                vectors++;
                if (match_count !== ec) begin
                    miscompares++;
                    $display("FAIL novl_cnt1 got %0d want %0d", match_count, ec);
                end
            end
        end
        ec = CNT_EN ? 8'd2 : 8'd0;
        vectors++;
        if (match_count !== ec) begin
            miscompares++;
            $display("FAIL novl_cnt2 got %0d want %0d", match_count, ec);
        end
        overlap_en = 1'b1;
    endtask

    task automatic test_gaps();
        logic [6:0] vld;
        logic [6:0] bits;
        logic [6:0] exp;
        vld  = 7'b1010011;
        bits = 7'b1101111;
        exp  = 7'b0000001;
        overlap_en = 1'b1;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            apply(vld[i], bits[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL gap_det step%0d got %b want %b", 7 - i, detector_out, exp[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [11:0] bits;
        logic [11:0] exp;
        logic [7:0]  ec;
        bits = 12'b1011_0110_1011;
        exp  = 12'b0001_0001_0000;
        overlap_en = 1'b1;
        do_reset();
        for (int i = 11; i >= 8; i--) begin
            apply(1'b1, bits[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL load_pre bit%0d got %b want %b", 12 - i, detector_out, exp[i]);
            end
        end
        pattern_in   = 4'b0110;
        pattern_load = 1'b1;
        valid_in     = 1'b1;
        sequence_in  = 1'b1;
        tick();
        pattern_load = 1'b0;
        valid_in     = 1'b0;
        vectors++;
        if (detector_out !== 1'b0) begin
            miscompares++;
            $display("FAIL load_cycle_det got %b want 0", detector_out);
        end
        for (int i = 7; i >= 0; i--) begin
            apply(1'b1, bits[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL load_post bit%0d got %b want %b", 8 - i, detector_out, exp[i]);
            end
        end
        ec = CNT_EN ? 8'd2 : 8'd0;
        vectors++;
        if (match_count !== ec) begin
            miscompares++;
            $display("FAIL load_cnt got %0d want %0d", match_count, ec);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp;
        logic [1:0] ec;
        logic [7:0] ew;
        exp = 8'b00011111;
        overlap_en = 1'b1;
        do_reset();
        pattern_in   = 4'b1111;
        pattern_load = 1'b1;
        tick();
        pattern_load = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            apply(1'b1, 1'b1);
            vectors++;
            if (det2 !== exp[i]) begin
                miscompares++;
                $display("FAIL sat_det bit%0d got %b want %b", 8 - i, det2, exp[i]);
            end
            if (i == 3) begin
                ec = CNT_EN ? 2'd2 : 2'd0;
                vectors++;
                if (cnt2 !== ec || sat2 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sat_mid got cnt=%0d sat=%b want cnt=%0d sat=0", cnt2, sat2, ec);
                end
            end
        end
        ec = CNT_EN ? 2'd3 : 2'd0;
        vectors++;
        if (cnt2 !== ec) begin
            miscompares++;
            $display("FAIL sat_cnt got %0d want %0d", cnt2, ec);
        end
        vectors++;
        if (sat2 !== CNT_EN) begin
            miscompares++;
            $display("FAIL sat_flag got %b want %b", sat2, CNT_EN);
        end
        ew = CNT_EN ? 8'd5 : 8'd0;
        vectors++;
        if (match_count !== ew) begin
            miscompares++;
            $display("FAIL wide_cnt got %0d want %0d", match_count, ew);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] pre;
        logic [3:0] post;
        logic [3:0] exp;
        pre  = 7'b0110101;
        post = 4'b1011;
        exp  = 4'b0001;
        overlap_en = 1'b1;
        do_reset();
        pattern_in   = 4'b0110;
        pattern_load = 1'b1;
        tick();
        pattern_load = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            apply(1'b1, pre[i]);
        end
        vectors++;
        if (match_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
            miscompares++;
            $display("FAIL rmid_pre_cnt got %0d", match_count);
        end
        reset        = 1'b1;
        valid_in     = 1'b1;
        sequence_in  = 1'b1;
        pattern_load = 1'b1;
        pattern_in   = 4'b1111;
        tick();
        reset        = 1'b0;
        valid_in     = 1'b0;
        pattern_load = 1'b0;
        vectors++;
        if (detector_out !== 1'b0 || match_count !== 8'd0 || count_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_outs got det=%b cnt=%0d sat=%b want 0 0 0",
                     detector_out, match_count, count_sat);
        end
        for (int i = 3; i >= 0; i--) begin
            apply(1'b1, post[i]);
            vectors++;
            if (detector_out !== exp[i]) begin
                miscompares++;
                $display("FAIL rmid_post bit%0d got %b want %b", 4 - i, detector_out, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_load();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
